// File: rtl/inst_mem_responder.sv
// inst_mem_responder
//   Instruction-fetch responder backed by a preloadable word memory.
//   One request at a time: a request is accepted in IDLE, the word (or an
//   error code) is captured at that edge, the response is released after
//   LATENCY wait cycles and held until the requester takes it.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   req_valid  fetch request present
//   req_ready  responder can accept (IDLE only)
//   req_addr   fetch byte address, sampled only at acceptance
//   rsp_valid  response present (RESP only)
//   rsp_ready  requester takes the response
//   rsp_data   instruction word, 0 on error
//   rsp_err    0 = ok, 1 = misaligned, 2 = out of range
//   wr_en      preload write strobe, any state, ignored during reset
//   wr_addr    preload word index
//   wr_data    preload word
//   fetch_cnt  completed response handshakes, wraps
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | ready for a request
// WAIT  | response captured, counting down LATENCY wait cycles
// RESP  | response presented, waiting for rsp_ready
module inst_mem_responder #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] BASE       = 32'h80000000,
   parameter int               DEPTH_LOG2 = 10,
   parameter int               LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [WIDTH-1:0]      req_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_data,
   output logic [1:0]            rsp_err,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_addr,
   input  logic [31:0]           wr_data,
   output logic [31:0]           fetch_cnt
);

   localparam int         DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [31:0]     rsp_data_q, rsp_data_d;
   logic [1:0]      rsp_err_q, rsp_err_d;
   logic [31:0]     fetch_cnt_q, fetch_cnt_d;

   logic [31:0]     mem_q [DEPTH];

   logic [WIDTH-1:0]      addr_off;
   logic                  addr_misaligned;
   logic                  addr_in_range;
   logic [DEPTH_LOG2-1:0] rd_idx;

   // Range check: first make sure the address is not below BASE, then the
   // offset is exact and only its bits above the memory span must be zero.
   // Nothing is ever added to the address, so the top of the address space
   // cannot wrap into the window.
   always_comb begin
      addr_off        = req_addr - BASE;
      addr_misaligned = (req_addr[1:0] != 2'b00);
      addr_in_range   = (req_addr >= BASE) && ((addr_off >> (DEPTH_LOG2 + 2)) == '0);
      rd_idx          = addr_off[DEPTH_LOG2+1:2];
   end

   // Preload port. The read in the next-state logic sees the pre-edge
   // contents, so a same-edge write to the fetched word returns old data.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         rsp_data_q  <= 32'd0;
         rsp_err_q   <= 2'd0;
         fetch_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      fetch_cnt_d = fetch_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (addr_misaligned) begin
                  rsp_err_d  = 2'd1;
                  rsp_data_d = 32'd0;
               end else if (!addr_in_range) begin
                  rsp_err_d  = 2'd2;
                  rsp_data_d = 32'd0;
               end else begin
                  rsp_err_d  = 2'd0;
                  rsp_data_d = mem_q[rd_idx];
               end
               if (LATENCY == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = LAT_M1;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               fetch_cnt_d = fetch_cnt_q + 32'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      req_ready = (state_q == ST_IDLE);
      rsp_valid = (state_q == ST_RESP);
      rsp_data  = rsp_data_q;
      rsp_err   = rsp_err_q;
      fetch_cnt = fetch_cnt_q;
   end

endmodule
